// File: rtl/master_port_if.sv
// Local request handshake plus the 1-bit decoder bus of the master port.
interface master_port_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic                  dvalid, dready, dwrite;
  logic [ADDR_WIDTH-1:0] daddr;
  logic [DATA_WIDTH-1:0] dwdata, drdata;
  logic                  ddone, derr;
  logic                  mwdata, mvalid, mmode;
  logic                  ack, sready, srdata, srvalid;

  modport master (
    input  dvalid, dwrite, daddr, dwdata, ack, sready, srdata, srvalid,
    output dready, drdata, ddone, derr, mwdata, mvalid, mmode
  );

  modport slave (
    output dvalid, dwrite, daddr, dwdata, ack, sready, srdata, srvalid,
    input  dready, drdata, ddone, derr, mwdata, mvalid, mmode
  );
endinterface

// File: rtl/master_port.sv
// Serialises device address, memory address and write data onto the 1-bit
// decoder bus, or collects serial read data, for one local request at a time.
module master_port #(
  parameter int ADDR_WIDTH        = 16,
  parameter int DEVICE_ADDR_WIDTH = 4,
  parameter int DATA_WIDTH        = 8,
  parameter int TIMEOUT           = 8
) (
  input  logic          clk,
  input  logic          rstn,
  master_port_if.master bus
);
  localparam int MEM_WIDTH = ADDR_WIDTH - DEVICE_ADDR_WIDTH;
  localparam int MAX_A     = (DEVICE_ADDR_WIDTH > ADDR_WIDTH) ? DEVICE_ADDR_WIDTH : ADDR_WIDTH;
  localparam int MAX_B     = (DATA_WIDTH > TIMEOUT) ? DATA_WIDTH : TIMEOUT;
  localparam int CNT_W     = $clog2((MAX_A > MAX_B) ? MAX_A : MAX_B) + 1;

  localparam logic [CNT_W-1:0] DEV_LAST = CNT_W'(DEVICE_ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] MEM_LAST = CNT_W'(MEM_WIDTH - 1);
  localparam logic [CNT_W-1:0] DAT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, DEV, WAIT_ACK, CONN, MADDR, WDATA, RDATA, RELEASE
  } state_e;

  state_e                       state_q;
  logic [CNT_W-1:0]             cnt_q;
  logic                         got_q;
  logic [DEVICE_ADDR_WIDTH-1:0] dev_q;
  logic [MEM_WIDTH-1:0]         mem_q;
  logic [DATA_WIDTH-1:0]        wd_q, drdata_q;
  logic                         dready_q, mvalid_q, mwdata_q, mmode_q, ddone_q, derr_q;
  logic [CNT_W-1:0]             ridx;

  // Index of the read bit arriving now; counter holds wait cycles until the first bit.
  assign ridx = got_q ? cnt_q : '0;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      got_q    <= 1'b0;
      dev_q    <= '0;
      mem_q    <= '0;
      wd_q     <= '0;
      drdata_q <= '0;
      dready_q <= 1'b1;
      mvalid_q <= 1'b0;
      mwdata_q <= 1'b0;
      mmode_q  <= 1'b0;
      ddone_q  <= 1'b0;
      derr_q   <= 1'b0;
    end else begin
      ddone_q <= 1'b0;
      derr_q  <= 1'b0;
      case (state_q)
        IDLE: if (bus.dvalid) begin
          state_q  <= DEV;
          cnt_q    <= '0;
          got_q    <= 1'b0;
          dready_q <= 1'b0;
          mvalid_q <= 1'b1;
          mwdata_q <= bus.daddr[MEM_WIDTH];
          dev_q    <= bus.daddr[ADDR_WIDTH-1 -: DEVICE_ADDR_WIDTH] >> 1;
          mem_q    <= bus.daddr[MEM_WIDTH-1:0];
          wd_q     <= bus.dwdata;
          mmode_q  <= bus.dwrite;
        end
        DEV: if (cnt_q == DEV_LAST) begin
          state_q  <= WAIT_ACK;
          cnt_q    <= '0;
          mvalid_q <= 1'b0;
          mwdata_q <= 1'b0;
        end else begin
          cnt_q    <= cnt_q + 1'b1;
          mwdata_q <= dev_q[0];
          dev_q    <= dev_q >> 1;
        end
        WAIT_ACK: if (bus.ack) begin
          state_q  <= CONN;
          cnt_q    <= '0;
          mvalid_q <= 1'b1;
          mwdata_q <= 1'b0;
        end else if (cnt_q == TO_LAST) begin
          state_q  <= IDLE;
          cnt_q    <= '0;
          derr_q   <= 1'b1;
          dready_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        CONN: begin
          state_q  <= MADDR;
          cnt_q    <= '0;
          mwdata_q <= mem_q[0];
          mem_q    <= mem_q >> 1;
        end
        MADDR: if (cnt_q == MEM_LAST) begin
          cnt_q <= '0;
          if (mmode_q) begin
            state_q  <= WDATA;
            mwdata_q <= wd_q[0];
            wd_q     <= wd_q >> 1;
          end else begin
            state_q  <= RDATA;
            mvalid_q <= 1'b0;
            mwdata_q <= 1'b0;
          end
        end else begin
          cnt_q    <= cnt_q + 1'b1;
          mwdata_q <= mem_q[0];
          mem_q    <= mem_q >> 1;
        end
        WDATA: if (cnt_q == DAT_LAST) begin
          state_q  <= RELEASE;
          cnt_q    <= '0;
          mvalid_q <= 1'b0;
          mwdata_q <= 1'b0;
        end else begin
          cnt_q    <= cnt_q + 1'b1;
          mwdata_q <= wd_q[0];
          wd_q     <= wd_q >> 1;
        end
        RDATA: if (bus.srvalid) begin
          drdata_q <= {bus.srdata, drdata_q[DATA_WIDTH-1:1]};
          got_q    <= 1'b1;
          if (ridx == DAT_LAST) begin
            state_q <= RELEASE;
            cnt_q   <= '0;
            got_q   <= 1'b0;
          end else begin
            cnt_q <= ridx + 1'b1;
          end
        end else if (!got_q) begin
          if (cnt_q == TO_LAST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            derr_q   <= 1'b1;
            dready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RELEASE: if (bus.sready) begin
          state_q  <= IDLE;
          cnt_q    <= '0;
          ddone_q  <= 1'b1;
          dready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.dready = dready_q;
  assign bus.drdata = drdata_q;
  assign bus.ddone  = ddone_q;
  assign bus.derr   = derr_q;
  assign bus.mwdata = mwdata_q;
  assign bus.mvalid = mvalid_q;
  assign bus.mmode  = mmode_q;
endmodule

// File: tb/tb_master_port.sv
// Randomised and directed bench for master_port; expected bus traces are built
// from the transaction phase lengths, not from the FSM.
module tb_master_port;
  localparam int AW = 16, DW = 4, W = 8, TO = 8, MW = AW - DW;
  localparam logic [4:0] E_DONE = 5'b10100, E_ERR = 5'b11000;

  logic clk = 1'b0, rstn = 1'b0;
  always #5 clk = ~clk;

  master_port_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(W)) bus ();
  master_port #(.ADDR_WIDTH(AW), .DEVICE_ADDR_WIDTH(DW), .DATA_WIDTH(W), .TIMEOUT(TO))
    dut (.clk(clk), .rstn(rstn), .bus(bus));

  int passed = 0, total = 0;
  // expected per cycle after accept: {dready, derr, ddone, mvalid, mwdata}
  logic [4:0] exp_q[$];
  logic [5:0] obs_q[$];
  bit st_ack[$], st_srv[$], st_srd[$], st_rdy[$];
  logic [W-1:0] last_rd;
  logic nxt_wr;
  logic [AW-1:0] nxt_a;
  logic [W-1:0] nxt_wd;

  task automatic push(input logic [4:0] e, input bit a, input bit sv, input bit sd, input bit rdy);
    exp_q.push_back(e); st_ack.push_back(a); st_srv.push_back(sv);
    st_srd.push_back(sd); st_rdy.push_back(rdy);
  endtask

  // ackd >= TO means no ack; gap0 >= TO means no read data.
  task automatic plan(input bit wr, input logic [AW-1:0] a, input logic [W-1:0] wd,
                      input int ackd, input int gap0, input logic [W-1:0] rdv,
                      input logic [W-1:0] holes, input int reld);
    exp_q.delete(); st_ack.delete(); st_srv.delete(); st_srd.delete(); st_rdy.delete();
    for (int k = 0; k < DW; k++) push({4'b0001, a[MW+k]}, 0, 0, 0, 1);
    if (ackd >= TO) begin
      for (int k = 0; k < TO; k++) push(5'b0, 0, 0, 0, 1);
      push(E_ERR, 0, 0, 0, 1);
      return;
    end
    for (int k = 0; k <= ackd; k++) push(5'b0, k == ackd, 0, 0, 1);
    push(5'b00010, 1, 0, 0, 1);
    for (int k = 0; k < MW; k++) push({4'b0001, a[k]}, 0, 0, 0, 1);
    if (wr) begin
      for (int k = 0; k < W; k++) push({4'b0001, wd[k]}, 0, 0, 0, 1);
    end else if (gap0 >= TO) begin
      for (int k = 0; k < TO; k++) push(5'b0, 0, 0, 0, 1);
      push(E_ERR, 0, 0, 0, 1);
      return;
    end else begin
      for (int k = 0; k < gap0; k++) push(5'b0, 0, 0, 0, 1);
      for (int k = 0; k < W; k++) begin
        push(5'b0, 0, 1, rdv[k], 1);
        if (k < W - 1 && holes[k]) push(5'b0, 0, 0, 0, 1);
      end
    end
    for (int k = 0; k < reld; k++) push(5'b0, 0, 0, 0, 0);
    push(5'b0, 0, 0, 0, 1);
    push(E_DONE, 0, 0, 0, 1);
  endtask

  task automatic run(input bit wr, input logic [AW-1:0] a, input logic [W-1:0] wd,
                     input bit noise, input bit chain, input bit pre);
    obs_q.delete();
    if (!pre) begin
      @(negedge clk);
      bus.dvalid = 1'b1; bus.dwrite = wr; bus.daddr = a; bus.dwdata = wd;
      bus.ack = 1'b0; bus.srvalid = 1'b0; bus.srdata = 1'b0; bus.sready = 1'b1;
    end
    for (int c = 0; c < exp_q.size(); c++) begin
      @(negedge clk);
      obs_q.push_back({bus.mmode, bus.dready, bus.derr, bus.ddone, bus.mvalid, bus.mwdata});
      last_rd = bus.drdata;
      if (chain) begin
        bus.dvalid = 1'b1; bus.dwrite = nxt_wr; bus.daddr = nxt_a; bus.dwdata = nxt_wd;
      end else if (noise && c < exp_q.size() - 1) begin
        bus.dvalid = 1'($urandom); bus.dwrite = 1'($urandom);
        bus.daddr = AW'($urandom); bus.dwdata = W'($urandom);
      end else begin
        bus.dvalid = 1'b0;
      end
      bus.ack = st_ack[c]; bus.srvalid = st_srv[c]; bus.srdata = st_srd[c]; bus.sready = st_rdy[c];
    end
  endtask

  task automatic test_reset;
    bus.dvalid = 1'b0; bus.dwrite = 1'b0; bus.daddr = '0; bus.dwdata = '0;
    bus.ack = 1'b0; bus.sready = 1'b0; bus.srdata = 1'b0; bus.srvalid = 1'b0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.dready, bus.mvalid, bus.mwdata, bus.mmode, bus.ddone, bus.derr} !== 6'b100000)
      $display("FAIL reset outputs got %b want 100000",
               {bus.dready, bus.mvalid, bus.mwdata, bus.mmode, bus.ddone, bus.derr});
    else passed++;
    total++;
    if (bus.drdata !== 8'h00) $display("FAIL reset drdata got %h want 00", bus.drdata);
    else passed++;
    rstn = 1'b1;
  endtask

  task automatic test_write;
    plan(1, 16'h2345, 8'hA5, 0, 0, 0, 0, 0);
    run(1, 16'h2345, 8'hA5, 0, 0, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== {1'b1, exp_q[i]})
        $display("FAIL write cyc%0d got %b want %b", i + 1, obs_q[i], {1'b1, exp_q[i]});
      else passed++;
    end
  endtask

  task automatic test_read;
    plan(0, 16'h1010, 8'h00, 0, 2, 8'h3C, 0, 0);
    run(0, 16'h1010, 8'h00, 0, 0, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== {1'b0, exp_q[i]})
        $display("FAIL read cyc%0d got %b want %b", i + 1, obs_q[i], {1'b0, exp_q[i]});
      else passed++;
    end
    total++;
    if (last_rd !== 8'h3C) $display("FAIL read drdata got %h want 3c", last_rd);
    else passed++;
  endtask

  task automatic test_timeout;
    plan(1, 16'h5123, 8'h0F, TO, 0, 0, 0, 0);
    run(1, 16'h5123, 8'h0F, 0, 0, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== {1'b1, exp_q[i]})
        $display("FAIL ack_timeout cyc%0d got %b want %b", i + 1, obs_q[i], {1'b1, exp_q[i]});
      else passed++;
    end
    // ack on the last allowed wait cycle, then no read data at all
    plan(0, 16'h7777, 8'h00, TO - 1, TO, 0, 0, 0);
    run(0, 16'h7777, 8'h00, 0, 0, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== {1'b0, exp_q[i]})
        $display("FAIL read_timeout cyc%0d got %b want %b", i + 1, obs_q[i], {1'b0, exp_q[i]});
      else passed++;
    end
  endtask

  task automatic test_dvalid_ignore;
    plan(1, 16'h9ABC, 8'h3E, 2, 0, 0, 0, 1);
    run(1, 16'h9ABC, 8'h3E, 1, 0, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== {1'b1, exp_q[i]})
        $display("FAIL ignore cyc%0d got %b want %b", i + 1, obs_q[i], {1'b1, exp_q[i]});
      else passed++;
    end
  endtask

  task automatic test_reset_mid;
    plan(1, 16'h5ABC, 8'h66, 1, 0, 0, 0, 0);
    @(negedge clk);
    bus.dvalid = 1'b1; bus.dwrite = 1'b1; bus.daddr = 16'h5ABC; bus.dwdata = 8'h66;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bus.dvalid = 1'b0;
      bus.ack = st_ack[c]; bus.srvalid = st_srv[c]; bus.srdata = st_srd[c]; bus.sready = st_rdy[c];
    end
    total++;
    if ({bus.dready, bus.derr, bus.ddone, bus.mvalid, bus.mwdata} !== exp_q[9])
      $display("FAIL rst_mid_pre got %b want %b",
               {bus.dready, bus.derr, bus.ddone, bus.mvalid, bus.mwdata}, exp_q[9]);
    else passed++;
    rstn = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.dready, bus.derr, bus.ddone, bus.mvalid, bus.mwdata} !== 5'b10000)
      $display("FAIL rst_mid got %b want 10000",
               {bus.dready, bus.derr, bus.ddone, bus.mvalid, bus.mwdata});
    else passed++;
    rstn = 1'b1; bus.ack = 1'b0;
    plan(1, 16'h0001, 8'hC3, 0, 0, 0, 0, 0);
    run(1, 16'h0001, 8'hC3, 0, 0, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== {1'b1, exp_q[i]})
        $display("FAIL post_rst cyc%0d got %b want %b", i + 1, obs_q[i], {1'b1, exp_q[i]});
      else passed++;
    end
  endtask

  task automatic test_back_to_back;
    nxt_wr = 1'b1; nxt_a = 16'hE00F; nxt_wd = 8'h81;
    plan(1, 16'h3C5A, 8'h5A, 1, 0, 0, 0, 3);
    run(1, 16'h3C5A, 8'h5A, 0, 1, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== {1'b1, exp_q[i]})
        $display("FAIL b2b_first cyc%0d got %b want %b", i + 1, obs_q[i], {1'b1, exp_q[i]});
      else passed++;
    end
    plan(1, 16'hE00F, 8'h81, 0, 0, 0, 0, 0);
    run(1, 16'hE00F, 8'h81, 0, 0, 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== {1'b1, exp_q[i]})
        $display("FAIL b2b_second cyc%0d got %b want %b", i + 1, obs_q[i], {1'b1, exp_q[i]});
      else passed++;
    end
  endtask

  task automatic test_random;
    bit wr, noise;
    logic [AW-1:0] a;
    logic [W-1:0] wd, rdv, holes;
    int ackd, gap0, reld;
    for (int n = 0; n < 24; n++) begin
      wr = 1'($urandom); noise = 1'($urandom);
      a = AW'($urandom); wd = W'($urandom); rdv = W'($urandom);
      holes = W'($urandom & $urandom & $urandom);
      ackd = $urandom_range(TO, 0); gap0 = $urandom_range(TO, 0); reld = $urandom_range(3, 0);
      plan(wr, a, wd, ackd, gap0, rdv, holes, reld);
      run(wr, a, wd, noise, 0, 0);
      for (int i = 0; i < exp_q.size(); i++) begin
        total++;
        if (obs_q[i] !== {wr, exp_q[i]})
          $display("FAIL rand%0d cyc%0d got %b want %b", n, i + 1, obs_q[i], {wr, exp_q[i]});
        else passed++;
      end
      if (!wr && ackd < TO && gap0 < TO) begin
        total++;
        if (last_rd !== rdv) $display("FAIL rand%0d drdata got %h want %h", n, last_rd, rdv);
        else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_dvalid_ignore();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
